// File: rtl/tt_capture7.sv
// tt_capture7: sweeps all 128 input combinations of a 7-input function under
// test, assembles its truth table, then streams it out as 32 hex nibbles,
// most significant nibble first.
//
// state | meaning
// IDLE  | waiting for start; probe held at 0, table stable
// SWEEP | driving probe 0..127 and sampling f_in into tt
// EMIT  | presenting tt nibbles 31..0 on a valid/ready stream
module tt_capture7 #(
  parameter int SAMPLE_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [6:0]   probe,
  input  logic         f_in,
  output logic [3:0]   nib,
  output logic         nib_valid,
  input  logic         nib_ready,
  output logic [127:0] tt,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT} state_t;

  // Pipeline depth is at least one so the arrays stay legal when SAMPLE_LAT=0;
  // in that case the pipeline is bypassed.
  localparam int PD = (SAMPLE_LAT > 0) ? SAMPLE_LAT : 1;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic           drv_done_q, drv_done_d;
  logic [127:0]   tt_q, tt_d;
  logic [4:0]     j_q, j_d;
  logic [4:0]     j_m1;
  logic [3:0]     nib_q, nib_d;
  logic           nib_valid_q, nib_valid_d;
  logic           done_q, done_d;
  logic [6:0]     idx_pipe_q [PD];
  logic           vld_pipe_q [PD];
  logic           drv_vld;
  logic [6:0]     smp_idx;
  logic           smp_vld;

  assign probe     = (state_q == SWEEP) ? cnt_q : 7'd0;
  assign tt        = tt_q;
  assign nib       = nib_q;
  assign nib_valid = nib_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Sample index/valid: the driven index delayed by SAMPLE_LAT cycles.
  always_comb begin
    drv_vld = (state_q == SWEEP) && !drv_done_q;
    smp_idx = (SAMPLE_LAT == 0) ? cnt_q   : idx_pipe_q[PD-1];
    smp_vld = (SAMPLE_LAT == 0) ? drv_vld : vld_pipe_q[PD-1];
    j_m1    = j_q - 5'd1;
  end

  // Next-state and datapath updates for the capture sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drv_done_d  = drv_done_q;
    tt_d        = tt_q;
    j_d         = j_q;
    nib_d       = nib_q;
    nib_valid_d = nib_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SWEEP;
          cnt_d      = 7'd0;
          drv_done_d = 1'b0;
          tt_d       = '0;
          j_d        = 5'd31;
        end
      end
      SWEEP: begin
        if (!drv_done_q) begin
          if (cnt_q == 7'd127) drv_done_d = 1'b1;
          else                 cnt_d = cnt_q + 7'd1;
        end
        if (smp_vld) begin
          tt_d[smp_idx] = f_in;
          if (smp_idx == 7'd127) begin
            // Load the first nibble from the table including this last write.
            state_d     = EMIT;
            nib_d       = tt_d[127:124];
            nib_valid_d = 1'b1;
            j_d         = 5'd31;
          end
        end
      end
      EMIT: begin
        if (nib_ready) begin
          if (j_q == 5'd0) begin
            state_d     = IDLE;
            nib_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            j_d   = j_m1;
            nib_d = tt_q[{j_m1, 2'b00} +: 4];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers plus the index/valid sample pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 7'd0;
      drv_done_q  <= 1'b0;
      tt_q        <= '0;
      j_q         <= 5'd0;
      nib_q       <= 4'd0;
      nib_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < PD; i++) begin
        idx_pipe_q[i] <= 7'd0;
        vld_pipe_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drv_done_q  <= drv_done_d;
      tt_q        <= tt_d;
      j_q         <= j_d;
      nib_q       <= nib_d;
      nib_valid_q <= nib_valid_d;
      done_q      <= done_d;
      if (state_q == IDLE && start) begin
        for (int i = 0; i < PD; i++) vld_pipe_q[i] <= 1'b0;
      end else if (state_q == SWEEP) begin
        idx_pipe_q[0] <= cnt_q;
        vld_pipe_q[0] <= drv_vld;
        for (int i = 1; i < PD; i++) begin
          idx_pipe_q[i] <= idx_pipe_q[i-1];
          vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_capture7.sv
// Testbench for tt_capture7: two instances (SAMPLE_LAT 0 and 2), directed FUTs
// with hand-written expected nibble streams, scoreboard queue checked by an
// independent monitor process.
module tb_tt_capture7;

  localparam logic [127:0] REF_TT = 128'hfeeaeae8eae8e888eee8e8a8e8a8a880;
  localparam logic [127:0] MAJ_TT = 128'he8e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8;
  localparam logic [127:0] X6_TT  = 128'hffffffffffffffff0000000000000000;
  localparam logic [127:0] X0_TT  = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start0 = 1'b0, start2 = 1'b0, rdy = 1'b1;
  logic [6:0]   probe0, probe2;
  logic         f0, f2, r1, r2;
  logic [3:0]   nib0, nib2;
  logic         val0, val2, busy0, busy2, done0, done2;
  logic [127:0] tt0, tt2;
  int           fsel = 0;
  int           sel  = 0;
  int           tests = 0, fails = 0;
  logic [3:0]   expq[$];

  logic [3:0]   v_nib;
  logic         v_valid, v_busy, v_done;
  logic [6:0]   v_probe;
  logic [127:0] v_tt;

  function automatic logic fut(input int f, input logic [6:0] p);
    logic [127:0] r;
    r = REF_TT;
    case (f)
      0: return 1'b0;
      1: return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
      2: return p[6];
      3: return p[0];
      default: return r[p];
    endcase
  endfunction

  function automatic logic [3:0] hexval(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'd48);
    return 4'(c - 8'd87);
  endfunction

  always_comb f0 = fut(fsel, probe0);
  always @(posedge clk) begin
    r1 <= fut(fsel, probe2);
    r2 <= r1;
  end
  assign f2 = r2;

  always_comb begin
    v_nib   = (sel == 0) ? nib0   : nib2;
    v_valid = (sel == 0) ? val0   : val2;
    v_busy  = (sel == 0) ? busy0  : busy2;
    v_done  = (sel == 0) ? done0  : done2;
    v_probe = (sel == 0) ? probe0 : probe2;
    v_tt    = (sel == 0) ? tt0    : tt2;
  end

  tt_capture7 #(.SAMPLE_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .probe(probe0), .f_in(f0),
    .nib(nib0), .nib_valid(val0), .nib_ready(rdy), .tt(tt0),
    .busy(busy0), .done(done0)
  );

  tt_capture7 #(.SAMPLE_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .probe(probe2), .f_in(f2),
    .nib(nib2), .nib_valid(val2), .nib_ready(rdy), .tt(tt2),
    .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic pv, pr;
    logic [3:0] pn;
    pv = 1'b0; pr = 1'b0; pn = 4'd0;
    forever begin
      @(negedge clk);
      if (v_valid) begin
        if (pv && !pr) chk("stall_hold", 128'(v_nib), 128'(pn));
        if (rdy) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_nib: got %h expected none", v_nib);
          end else begin
            chk("nib", 128'(v_nib), 128'(expq.pop_front()));
          end
        end
      end
      if (v_done) chk("done_after_last", 128'(expq.size()), 128'd0);
      pv = v_valid;
      pr = rdy;
      pn = v_nib;
    end
  endtask

  task automatic run(input int s, input int f, input bit bp, input bit inj,
                     input logic [127:0] exp_tt, input string exp_s,
                     input int exp_cyc, input int exp_sweep);
    int cyc, sw, em, pexp, busy_bad, probe_bad;
    bit got_done, st;
    sel = s;
    fsel = f;
    for (int i = 0; i < 32; i++) expq.push_back(hexval(exp_s.getc(i)));
    @(posedge clk); #1;
    if (s == 0) start0 = 1'b1; else start2 = 1'b1;
    rdy = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    cyc = 1; sw = 0; em = 0; pexp = 0; busy_bad = 0; probe_bad = 0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      if (v_done) begin
        got_done = 1'b1;
      end else begin
        if (!v_busy) busy_bad++;
        if (v_busy && !v_valid) begin
          if (v_probe != 7'(pexp)) probe_bad++;
          if (pexp < 127) pexp++;
          sw++;
        end
        if (v_valid) em++;
        @(posedge clk); #1;
        cyc++;
        if (bp) rdy = ($urandom_range(0, 99) < 30);
        if (inj) begin
          st = (sw == 50) || (em == 3);
          if (s == 0) start0 = st; else start2 = st;
        end
      end
    end
    start0 = 1'b0; start2 = 1'b0;
    chk("done_seen", 128'(got_done), 128'd1);
    if (!got_done) expq.delete();
    if (exp_cyc > 0) chk("done_cycle", 128'(cyc), 128'(exp_cyc));
    chk("busy_run", 128'(busy_bad), 128'd0);
    chk("probe_seq", 128'(probe_bad), 128'd0);
    chk("sweep_len", 128'(sw), 128'(exp_sweep));
    chk("tt", v_tt, exp_tt);
    @(posedge clk); #1;
    rdy = 1'b1;
    @(negedge clk);
    chk("idle_after_done", 128'({v_busy, v_done, v_valid}), 128'd0);
  endtask

  initial begin
    bit seen_done, hit;
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_probe", 128'(probe0), 128'd0);
    chk("rst_tt", tt0, 128'd0);
    chk("rst_nib", 128'(nib0), 128'd0);
    chk("rst_valid", 128'(val0), 128'd0);
    chk("rst_busy", 128'({busy0, busy2}), 128'd0);
    chk("rst_done", 128'({done0, done2}), 128'd0);
    chk("rst_tt2", tt2, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(0, 1, 0, 0, MAJ_TT, "e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8", 161, 128);
    run(0, 2, 0, 0, X6_TT,  "ffffffffffffffff0000000000000000", 161, 128);
    run(0, 3, 0, 0, X0_TT,  "aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa", 161, 128);
    run(0, 0, 0, 0, 128'd0, "00000000000000000000000000000000", 161, 128);
    run(1, 4, 0, 0, REF_TT, "feeaeae8eae8e888eee8e8a8e8a8a880", 163, 130);
    run(1, 4, 1, 0, REF_TT, "feeaeae8eae8e888eee8e8a8e8a8a880", 0, 130);

    // Abort a sweep at index 60 with reset, then recapture.
    sel = 0; fsel = 1;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (busy0 && probe0 == 7'd60) hit = 1'b1;
    end
    chk("reach_idx60", 128'(hit), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tt", tt0, 128'd0);
    chk("abort_busy", 128'(busy0), 128'd0);
    chk("abort_valid", 128'(val0), 128'd0);
    chk("abort_probe", 128'(probe0), 128'd0);
    seen_done = done0;
    repeat (5) begin
      @(negedge clk);
      seen_done = seen_done | done0 | busy0;
    end
    chk("abort_quiet", 128'(seen_done), 128'd0);
    run(0, 1, 0, 0, MAJ_TT, "e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8", 161, 128);

    // Spurious start pulses during SWEEP and EMIT.
    run(0, 2, 0, 1, X6_TT,  "ffffffffffffffff0000000000000000", 161, 128);
    run(1, 4, 0, 1, REF_TT, "feeaeae8eae8e888eee8e8a8e8a8a880", 163, 130);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
